// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    // Width of the oversample edge counter; it must hold the largest prescale minus one.
    localparam int EDGE_W = 6;
    // Width of the frame bit counter; it must hold start + data + parity + stop.
    localparam int BIT_W  = 4;

    // Legal oversampling ratios.
    localparam logic [EDGE_W-1:0] PRESCALE_8  = EDGE_W'(8);
    localparam logic [EDGE_W-1:0] PRESCALE_16 = EDGE_W'(16);
    localparam logic [EDGE_W-1:0] PRESCALE_32 = EDGE_W'(32);

    // Ratio assumed out of reset, before any frame has latched one.
    localparam logic [EDGE_W-1:0] PRESCALE_RST = PRESCALE_8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Edge index on which a bit ends. An illegal ratio of 0 wraps to the
    // all-ones index, so the count stays bounded for any ratio.
    function automatic logic [EDGE_W-1:0] last_edge(input logic [EDGE_W-1:0] p);
        return p - EDGE_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter, with a bit-end wrap pulse.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [EDGE_W-1:0] p,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              wrap
);

    // Bit end: the last oversample edge of the current bit while counting.
    assign wrap = en && (edge_count == last_edge(p));

    // Count edges within a bit, and bits within the frame at each wrap.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (clr) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (en) begin
            if (wrap) begin
                edge_count <= '0;
                bit_count  <= bit_count + BIT_W'(1);
            end else begin
                edge_count <= edge_count + EDGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop bits,
// enables the checkers in their own bit and reports the frame outcome.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [5:0]        prescale,
    input  logic              par_en,
    input  logic              sampled_bit,
    input  logic              strt_glitch,
    input  logic              par_err_in,
    input  logic              stp_err_in,
    output logic [5:0]        edge_count,
    output logic [3:0]        bit_count,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              strt_chk_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid,
    output logic              par_err,
    output logic              framing_err
);

    rx_state_t         state;
    rx_state_t         next_state;
    logic [EDGE_W-1:0] p_lat;
    logic              par_en_lat;
    logic              par_sticky;
    logic              wrap;
    logic              start_detect;

    // The sampled bit is consumed by the deserializer, not by this controller.
    logic unused_sampled_bit;
    assign unused_sampled_bit = sampled_bit;

    assign start_detect = (state == IDLE) && !rx_in;

    uart_rx_edge_bit_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (state != IDLE),
        .clr        (next_state == IDLE),
        .p          (p_lat),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .wrap       (wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state checker enables.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        next_state  = state;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_in) begin
                    next_state = START;
                end
            end
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
                if (wrap) begin
                    next_state = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
                if (wrap && (bit_count == BIT_W'(DATA_WIDTH))) begin
                    next_state = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
                if (wrap) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
                if (wrap) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame configuration is frozen at start detect; later changes wait for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_lat      <= PRESCALE_RST;
            par_en_lat <= 1'b0;
        end else if (start_detect) begin
            p_lat      <= prescale;
            par_en_lat <= par_en;
        end
    end

    // Parity failure is remembered until the stop bit reports the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_sticky <= 1'b0;
        end else if (start_detect) begin
            par_sticky <= 1'b0;
        end else if ((state == PARITY) && wrap) begin
            par_sticky <= par_err_in;
        end
    end

    // One-cycle outcome pulses, issued the cycle after the stop bit ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            framing_err <= 1'b0;
        end else if ((state == STOP) && wrap) begin
            data_valid  <= !stp_err_in && !par_sticky;
            par_err     <= par_sticky;
            framing_err <= stp_err_in;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            framing_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame scenarios followed by
// randomized traffic, all compared cycle by cycle against a frame-schedule model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       par_err_in = 1'b0;
    logic       stp_err_in = 1'b0;

    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, par_err, framing_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observed outputs of the most recent cycle.
    logic [5:0] o_edge;
    logic [3:0] o_bit;
    logic       o_samp, o_deser, o_strt, o_par, o_stp, o_dv, o_perr, o_ferr;

    // Reference model: a frame is a schedule of bits, each P cycles long.
    bit m_active, m_pe, m_sticky, m_dv, m_perr, m_ferr;
    int m_k, m_p;
    int m_dv_total = 0;
    int o_dv_total = 0;

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .sampled_bit (sampled_bit),
        .strt_glitch (strt_glitch),
        .par_err_in  (par_err_in),
        .stp_err_in  (stp_err_in),
        .edge_count  (edge_count),
        .bit_count   (bit_count),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .framing_err (framing_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] dut_vec();
        return {edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
                par_chk_en, stp_chk_en, data_valid, par_err, framing_err};
    endfunction

    task automatic model_reset();
        m_active = 0; m_pe = 0; m_sticky = 0;
        m_dv = 0; m_perr = 0; m_ferr = 0;
        m_k = 0; m_p = 8;
    endtask

    // Expected outputs for the current cycle, derived from the position in the frame.
    function automatic logic [17:0] model_vec();
        int b, e, last;
        logic samp, des, st, pa, sp;
        b = 0; e = 0; samp = 0; des = 0; st = 0; pa = 0; sp = 0;
        if (m_active) begin
            b    = m_k / m_p;
            e    = m_k % m_p;
            last = DW + 1 + int'(m_pe);
            samp = 1;
            st   = (b == 0);
            des  = (b >= 1) && (b <= DW);
            pa   = m_pe && (b == DW + 1);
            sp   = (b == last);
        end
        return {6'(e), 4'(b), samp, des, st, pa, sp, m_dv, m_perr, m_ferr};
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_advance();
        int b, e, last;
        if (!rst) begin
            model_reset();
            return;
        end
        m_dv = 0; m_perr = 0; m_ferr = 0;
        if (!m_active) begin
            if (!rx_in) begin
                m_active = 1; m_k = 0; m_p = int'(prescale);
                m_pe = par_en; m_sticky = 0;
            end
        end else begin
            b    = m_k / m_p;
            e    = m_k % m_p;
            last = DW + 1 + int'(m_pe);
            if (e == m_p - 1) begin
                if (b == 0 && strt_glitch) begin
                    m_active = 0;
                end else if (b == last) begin
                    m_dv     = !stp_err_in && !m_sticky;
                    m_perr   = m_sticky;
                    m_ferr   = stp_err_in;
                    m_active = 0;
                end else if (m_pe && b == DW + 1) begin
                    m_sticky = par_err_in;
                end
            end
            m_k++;
        end
    endtask

    // One clock: compare at the falling edge, step the model, return just after the rising edge.
    task automatic run_cycle();
        logic [17:0] ev;
        @(negedge clk);
        {o_edge, o_bit, o_samp, o_deser, o_strt, o_par, o_stp, o_dv, o_perr, o_ferr} = dut_vec();
        ev = model_vec();
        if (ev[2]) m_dv_total++;
        if (o_dv) o_dv_total++;
        check($sformatf("cycle%0d", cyc), 32'(dut_vec()), 32'(ev));
        model_advance();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Run one frame (start already detected) to the first idle cycle, collecting statistics.
    task automatic frame_measure(input int max_cycles, input bit b2b, input int p,
                                 input int chg_bit, input logic [5:0] chg_p,
                                 output int samp_n, output int deser_n, output int dv_n,
                                 output int pe_n, output int fe_n, output int max_bit,
                                 output int dv_at);
        bit seen, done;
        seen = 0; done = 0;
        samp_n = 0; deser_n = 0; dv_n = 0; pe_n = 0; fe_n = 0; max_bit = 0; dv_at = -1;
        for (int i = 0; i < max_cycles && !done; i++) begin
            run_cycle();
            if (o_samp) begin samp_n++; seen = 1; end
            if (o_deser) deser_n++;
            if (o_dv) begin dv_n++; dv_at = samp_n; end
            if (o_perr) pe_n++;
            if (o_ferr) fe_n++;
            if (int'(o_bit) > max_bit) max_bit = int'(o_bit);
            if (o_deser && int'(o_bit) == chg_bit) prescale = chg_p;
            if (b2b && o_stp && int'(o_edge) == p - 1) begin
                rx_in      = 1'b0;
                stp_err_in = 1'b0;
            end
            if (seen && !o_samp) done = 1;
        end
        check("frame_completed_in_bound", 32'(done), 32'd1);
    endtask

    task automatic detect_start();
        rx_in = 1'b0;
        run_cycle();
        rx_in = 1'b1;
    endtask

    int samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at;
    int en_cnt, pulse_cnt;
    bit found;

    initial begin
        // Reset state.
        model_reset();
        #1;
        check("reset_state", 32'(dut_vec()), 32'd0);
        run_cycle();
        run_cycle();
        rst = 1'b1;
        repeat (3) run_cycle();

        // Clean 8-bit frame at prescale 8 without parity.
        prescale = PRESCALE_8; par_en = 1'b0;
        detect_start();
        frame_measure(200, 0, 8, -1, 6'd0, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("p8_frame_cycles", 32'(samp_n), 32'd80);
        check("p8_deser_cycles", 32'(deser_n), 32'd64);
        check("p8_dv_count", 32'(dv_n), 32'd1);
        check("p8_dv_delay", 32'(dv_at), 32'd80);
        check("p8_err_pulses", 32'(pe_n + fe_n), 32'd0);
        repeat (4) run_cycle();

        // Parity frame at prescale 16 with a parity failure.
        prescale = PRESCALE_16; par_en = 1'b1; par_err_in = 1'b1;
        detect_start();
        par_en = 1'b0;
        frame_measure(400, 0, 16, -1, 6'd0, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("p16_frame_cycles", 32'(samp_n), 32'd176);
        check("p16_par_err", 32'(pe_n), 32'd1);
        check("p16_no_dv", 32'(dv_n), 32'd0);
        check("p16_max_bit", 32'(max_bit), 32'd10);
        par_err_in = 1'b0;
        repeat (4) run_cycle();

        // Start glitch aborts after one bit time.
        prescale = PRESCALE_8; strt_glitch = 1'b1;
        detect_start();
        frame_measure(50, 0, 8, -1, 6'd0, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("glitch_cycles", 32'(samp_n), 32'd8);
        check("glitch_pulses", 32'(dv_n + pe_n + fe_n), 32'd0);
        strt_glitch = 1'b0;
        en_cnt = 0; pulse_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            en_cnt    += int'(o_samp) + int'(o_deser) + int'(o_strt) + int'(o_par) + int'(o_stp);
            pulse_cnt += int'(o_dv) + int'(o_perr) + int'(o_ferr);
        end
        check("glitch_idle_enables", 32'(en_cnt), 32'd0);
        check("glitch_idle_pulses", 32'(pulse_cnt), 32'd0);

        // Stop error, then a back-to-back frame starting in the first idle cycle.
        prescale = PRESCALE_8; par_en = 1'b0; stp_err_in = 1'b1;
        detect_start();
        frame_measure(200, 1, 8, -1, 6'd0, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("stperr_framing", 32'(fe_n), 32'd1);
        check("stperr_other_pulses", 32'(dv_n + pe_n), 32'd0);
        rx_in = 1'b1;
        frame_measure(200, 0, 8, -1, 6'd0, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("b2b_frame_cycles", 32'(samp_n), 32'd80);
        check("b2b_dv", 32'(dv_n), 32'd1);
        check("b2b_err_pulses", 32'(pe_n + fe_n), 32'd0);

        // Prescale change mid-frame takes effect only on the next frame.
        prescale = PRESCALE_8;
        detect_start();
        frame_measure(200, 0, 8, 3, PRESCALE_32, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("pchg_frame_cycles", 32'(samp_n), 32'd80);
        check("pchg_dv", 32'(dv_n), 32'd1);
        detect_start();
        frame_measure(800, 0, 32, -1, 6'd0, samp_n, deser_n, dv_n, pe_n, fe_n, max_bit, dv_at);
        check("p32_frame_cycles", 32'(samp_n), 32'd320);
        check("p32_dv", 32'(dv_n), 32'd1);

        // Reset in the middle of the data bits.
        prescale = PRESCALE_8;
        detect_start();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            run_cycle();
            if (o_deser && o_bit == 4'd4) found = 1;
        end
        check("reached_bit4", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'(dut_vec()), 32'd0);
        model_reset();
        run_cycle();
        run_cycle();
        rst = 1'b1;
        en_cnt = 0; pulse_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            run_cycle();
            en_cnt    += int'(o_samp);
            pulse_cnt += int'(o_dv) + int'(o_perr) + int'(o_ferr);
        end
        check("post_reset_idle", 32'(en_cnt), 32'd0);
        check("post_reset_no_pulse", 32'(pulse_cnt), 32'd0);

        // Randomized traffic: every input churns each cycle, including mid-frame configuration.
        m_dv_total = 0; o_dv_total = 0;
        for (int i = 0; i < 6000; i++) begin
            rx_in       = ($urandom_range(0, 2) != 0);
            sampled_bit = 1'($urandom);
            strt_glitch = ($urandom_range(0, 7) == 0);
            par_err_in  = ($urandom_range(0, 3) == 0);
            stp_err_in  = ($urandom_range(0, 3) == 0);
            par_en      = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       prescale = PRESCALE_8;
                1:       prescale = PRESCALE_16;
                default: prescale = PRESCALE_32;
            endcase
            run_cycle();
        end
        check("random_dv_total", 32'(o_dv_total), 32'(m_dv_total));
        check("random_frames_seen", 32'(m_dv_total > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
